uart_program_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the instruction fetch stage. It receives a program image over a UART serial line, assembles little-endian 32-bit words, and writes them into instruction memory through a single write port. It holds the core pipeline in reset until the image is fully and correctly loaded, then releases it so fetch starts at PC 0.

---
 rtl/uart_program_loader_pkg.sv | 14 +
 rtl/uart_program_loader_uart_rx.sv | 83 ++++++++
 rtl/uart_program_loader.sv | 123 ++++++++++++
 tb/tb_uart_program_loader.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_program_loader_pkg.sv
// Shared types for the UART boot loader: FSM state encoding and the IMEM base address.
package uart_program_loader_pkg;

    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } loader_state_t;

    localparam logic [31:0] IMEM_BASE_ADDR = 32'h0;

endpackage

// File: rtl/uart_program_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, start-bit glitch rejection.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       rx_ferr
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int HALF  = CLKS_PER_BIT / 2;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    rx_state_t        state, next_state;
    logic [1:0]       sync;
    logic             rx_s, rx_prev;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             bit_tick, half_tick;

    assign rx_s      = sync[1];
    assign bit_tick  = (cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign half_tick = (cnt == CNT_W'(HALF - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= R_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            R_IDLE:  if (rx_prev && !rx_s) next_state = R_START;
            R_START: if (half_tick) next_state = rx_s ? R_IDLE : R_DATA;
            R_DATA:  if (bit_tick && bit_idx == 3'd7) next_state = R_STOP;
            R_STOP:  if (bit_tick) next_state = R_IDLE;
            default: next_state = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync     <= 2'b11;
            rx_prev  <= 1'b1;
            cnt      <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            rx_byte  <= '0;
        end else begin
            sync     <= {sync[0], rx};
            rx_prev  <= rx_s;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            // Counter restarts at the half-bit point so data samples land mid-bit.
            if (state == R_IDLE || bit_tick || (state == R_START && half_tick))
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);
            if (state == R_IDLE)
                bit_idx <= '0;
            if (state == R_DATA && bit_tick) begin
                shift   <= {rx_s, shift[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
            if (state == R_STOP && bit_tick) begin
                if (rx_s) begin
                    rx_valid <= 1'b1;
                    rx_byte  <= shift;
                end else begin
                    rx_ferr  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_program_loader.sv
// Boot loader: UART image -> IMEM writes, holds the core in reset until loaded.
// Optional trailing checksum byte enabled by defining LOADER_CHECKSUM_EN.
module uart_program_loader
    import uart_program_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int IMEM_WORDS   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst,
    output logic        load_done,
    output logic        load_error
);

    localparam int IDX_W = $clog2(IMEM_WORDS + 1);

`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_t S_AFTER = S_CSUM;
    logic [7:0] sum;
`else
    localparam loader_state_t S_AFTER = S_DONE;
`endif

    loader_state_t    state, next_state;
    logic             rx_valid, rx_ferr;
    logic [7:0]       rx_byte;
    logic [1:0]       byte_cnt;
    logic [IDX_W-1:0] word_idx, n_words;
    logic [31:0]      asm_q, asm_next;
    logic             last_byte;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .rx       (uart_rx),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte),
        .rx_ferr  (rx_ferr)
    );

    // Little-endian: the first byte ends up in [7:0] after four shifts.
    assign asm_next  = {rx_byte, asm_q[31:8]};
    assign last_byte = (byte_cnt == 2'd3);

    assign core_rst   = (state != S_DONE);
    assign load_done  = (state == S_DONE);
    assign load_error = (state == S_ERR);

    always_ff @(posedge clk) begin
        if (rst) state <= S_LEN;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_LEN: begin
                if (rx_ferr)
                    next_state = S_ERR;
                else if (rx_valid && last_byte) begin
                    if (asm_next == 32'd0)                 next_state = S_AFTER;
                    else if (asm_next > 32'(IMEM_WORDS))   next_state = S_ERR;
                    else                                   next_state = S_DATA;
                end
            end
            S_DATA: begin
                if (rx_ferr)
                    next_state = S_ERR;
                else if (rx_valid && last_byte && (word_idx + IDX_W'(1)) == n_words)
                    next_state = S_AFTER;
            end
            S_CSUM: begin
`ifdef LOADER_CHECKSUM_EN
                if (rx_ferr)
                    next_state = S_ERR;
                else if (rx_valid)
                    next_state = (8'(sum + rx_byte) == 8'h00) ? S_DONE : S_ERR;
`endif
            end
            default: next_state = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt   <= '0;
            word_idx   <= '0;
            n_words    <= '0;
            asm_q      <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum        <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
            if (rx_valid && (state == S_LEN || state == S_DATA)) begin
                asm_q    <= asm_next;
                byte_cnt <= byte_cnt + 2'd1;
                if (state == S_LEN && last_byte)
                    n_words <= asm_next[IDX_W-1:0];
                if (state == S_DATA) begin
`ifdef LOADER_CHECKSUM_EN
                    sum <= sum + rx_byte;
`endif
                    if (last_byte) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= IMEM_BASE_ADDR + (32'(word_idx) << 2);
                        imem_wdata <= asm_next;
                        word_idx   <= word_idx + IDX_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// Scoreboard bench for uart_program_loader; follows LOADER_CHECKSUM_EN when defined.
module tb_uart_program_loader;

    localparam int CPB   = 4;
    localparam int WORDS = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_rx = 1'b1;
    logic        imem_we;
    logic [31:0] imem_addr, imem_wdata;
    logic        core_rst, load_done, load_error;

    uart_program_loader #(.CLKS_PER_BIT(CPB), .IMEM_WORDS(WORDS)) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_rx    (uart_rx),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          nwrites = 0;
    logic        done_at_last_we = 1'b0;
    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    logic [7:0]  img [8] = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Scoreboard: every IMEM write must match the oldest pending expectation.
    always @(negedge clk) begin
        if (imem_we) begin
            nwrites++;
            if (q_addr.size() == 0)
                chk("spur_we", 32'(imem_we), 32'd0);
            else begin
                chk("we_addr", imem_addr, q_addr.pop_front());
                chk("we_data", imem_wdata, q_data.pop_front());
            end
            if (imem_addr == 32'h4) done_at_last_we = load_done;
        end
    end

    task automatic send_bit(input logic v);
        uart_rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        uart_rx = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_we"},    32'(imem_we),    32'd0);
        chk({tag, "_addr"},  imem_addr,       32'd0);
        chk({tag, "_wdata"}, imem_wdata,      32'd0);
        chk({tag, "_crst"},  32'(core_rst),   32'd1);
        chk({tag, "_done"},  32'(load_done),  32'd0);
        chk({tag, "_err"},   32'(load_error), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        nwrites = 0;
    endtask

    // Header N=2, then nbytes of the image; checksum (if built) only for a full image.
    task automatic send_image(input int nbytes, input logic [7:0] csum_flip);
        logic [7:0] sum;
        sum = 8'h00;
        send_byte(8'h02, 1'b1);
        for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1);
        for (int i = 0; i < nbytes; i++) begin
            if (i % 4 == 3) begin
                q_addr.push_back(32'((i / 4) * 4));
                q_data.push_back({img[i], img[i-1], img[i-2], img[i-3]});
            end
            sum = sum + img[i];
            send_byte(img[i], 1'b1);
        end
`ifdef LOADER_CHECKSUM_EN
        if (nbytes == 8) send_byte((8'h00 - sum) ^ csum_flip, 1'b1);
`else
        if (csum_flip != 8'h00) sum = 8'h00;
`endif
    endtask

    task automatic wait_end(input string tag);
        for (int i = 0; i < 2000 && !(load_done || load_error); i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_finished"}, 32'(load_done | load_error), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        uart_rx = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("rst0");
        do_reset();

        // Good two-word image.
        send_image(8, 8'h00);
        wait_end("good");
        chk("good_done", 32'(load_done), 32'd1);
        chk("good_crst", 32'(core_rst), 32'd0);
        chk("good_err", 32'(load_error), 32'd0);
        chk("good_nwr", 32'(nwrites), 32'd2);
        chk("good_sb", 32'(q_addr.size()), 32'd0);
`ifdef LOADER_CHECKSUM_EN
        chk("good_done_at_we", 32'(done_at_last_we), 32'd0);
`else
        chk("good_done_at_we", 32'(done_at_last_we), 32'd1);
`endif

        // Length larger than memory.
        do_reset();
        send_byte(8'h09, 1'b1);
        for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1);
        wait_end("len");
        chk("len_err", 32'(load_error), 32'd1);
        chk("len_crst", 32'(core_rst), 32'd1);
        chk("len_done", 32'(load_done), 32'd0);
        chk("len_nwr", 32'(nwrites), 32'd0);

`ifdef LOADER_CHECKSUM_EN
        // Wrong checksum: words still written, then error.
        do_reset();
        send_image(8, 8'h01);
        wait_end("csum");
        chk("csum_err", 32'(load_error), 32'd1);
        chk("csum_crst", 32'(core_rst), 32'd1);
        chk("csum_nwr", 32'(nwrites), 32'd2);
        chk("csum_sb", 32'(q_addr.size()), 32'd0);
`endif

        // Framing error on the third data byte.
        do_reset();
        send_byte(8'h02, 1'b1);
        for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1);
        send_byte(img[0], 1'b1);
        send_byte(img[1], 1'b1);
        send_byte(img[2], 1'b0);
        wait_end("ferr");
        chk("ferr_err", 32'(load_error), 32'd1);
        chk("ferr_crst", 32'(core_rst), 32'd1);
        chk("ferr_nwr", 32'(nwrites), 32'd0);

        // One-cycle glitch on idle line must not start a byte.
        do_reset();
        uart_rx = 1'b0;
        @(posedge clk);
        #1;
        uart_rx = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        chk("glitch_done", 32'(load_done), 32'd0);
        chk("glitch_err", 32'(load_error), 32'd0);
        send_image(8, 8'h00);
        wait_end("glitch");
        chk("glitch_load", 32'(load_done), 32'd1);
        chk("glitch_nwr", 32'(nwrites), 32'd2);

        // Reset mid-image, then full resend.
        do_reset();
        send_image(5, 8'h00);
        repeat (5) @(posedge clk);
        #1;
        chk("mid_nwr", 32'(nwrites), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("mid_rst");
        rst = 1'b0;
        send_image(8, 8'h00);
        wait_end("resend");
        chk("resend_done", 32'(load_done), 32'd1);
        chk("resend_crst", 32'(core_rst), 32'd0);
        chk("resend_nwr", 32'(nwrites), 32'd3);
        chk("resend_sb", 32'(q_addr.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
